// File: rtl/unary_add_pkg.sv
// Shared types and constants for the unary adder controller.
// Holds the FSM state enum and the adder read/write phase encoding.
package unary_add_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
    localparam int UNARY_W = 8;
    localparam logic RW_READ = 1'b0;
    localparam logic RW_WRITE = 1'b1;
endpackage

// File: rtl/unary_add_ctrl_stream_gen.sv
// Down-counter that emits one registered unary pulse per count.
// empty means no pulses remain after the one currently shown.
module unary_stream_gen #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] val,
    output logic             pulse,
    output logic             empty
);
    logic [WIDTH-1:0] cnt;

    assign empty = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            pulse <= 1'b0;
        end else if (load) begin
            pulse <= (val != '0);
            cnt   <= (val != '0) ? val - WIDTH'(1) : '0;
        end else if (step) begin
            pulse <= (cnt != '0);
            if (cnt != '0)
                cnt <= cnt - WIDTH'(1);
        end
    end
endmodule

// File: rtl/unary_add_ctrl.sv
// Binary front/back end for the unary accumulator stage.
// Define UNARY_ADD_CTRL_SAT_EN to saturate res_sum on overflow.
module unary_add_ctrl
    import unary_add_pkg::*;
#(
    parameter int WIDTH = UNARY_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             add_a,
    output logic             add_b,
    output logic             add_en,
    output logic             add_rw,
    input  logic             add_dout,
    input  logic             add_c,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_ovf
);
    state_t           state;
    state_t           state_nxt;
    logic             first;
    logic             ovf;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sum_out;
    logic             accept;
    logic             step;
    logic             a_empty;
    logic             b_empty;

    assign accept = (state == IDLE) && in_valid && in_ready;
    assign step   = (state == LOAD);

`ifdef UNARY_ADD_CTRL_SAT_EN
    assign sum_out = ovf ? '1 : acc;
`else
    assign sum_out = acc;
`endif

    unary_stream_gen #(.WIDTH(WIDTH)) u_gen_a (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .step  (step),
        .val   (op_a),
        .pulse (add_a),
        .empty (a_empty)
    );

    unary_stream_gen #(.WIDTH(WIDTH)) u_gen_b (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .step  (step),
        .val   (op_b),
        .pulse (add_b),
        .empty (b_empty)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept)
                    state_nxt = (op_a != '0 || op_b != '0) ? LOAD : DRAIN;
            end
            LOAD: begin
                if (a_empty && b_empty)
                    state_nxt = DRAIN;
            end
            // dout lags by one, so the first drain cycle carries no data
            DRAIN: begin
                if (!first && !add_dout)
                    state_nxt = DONE;
            end
            DONE: begin
                if (res_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            first     <= 1'b0;
            ovf       <= 1'b0;
            acc       <= '0;
            in_ready  <= 1'b1;
            add_en    <= 1'b0;
            add_rw    <= RW_READ;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_ovf   <= 1'b0;
        end else begin
            state     <= state_nxt;
            first     <= (state_nxt != state);
            in_ready  <= (state_nxt == IDLE);
            add_en    <= (state_nxt == LOAD) || (state_nxt == DRAIN);
            add_rw    <= (state_nxt == DRAIN) ? RW_WRITE : RW_READ;
            res_valid <= (state_nxt == DONE);
            if (accept) begin
                acc <= '0;
                ovf <= 1'b0;
            end
            if (state == LOAD && !first)
                ovf <= ovf | add_c;
            if (state == DRAIN) begin
                if (first)
                    ovf <= ovf | add_c;
                else if (add_dout)
                    acc <= acc + WIDTH'(1);
            end
            if (state == DRAIN && state_nxt == DONE) begin
                res_sum <= sum_out;
                res_ovf <= ovf;
            end
        end
    end
endmodule

// File: tb/tb_unary_add_ctrl.sv
// Self-checking bench for unary_add_ctrl with a behavioural unary adder.
// Results are checked against plain binary arithmetic on the operands.
module tb_unary_add_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         add_a, add_b, add_en, add_rw;
    logic         add_dout, add_c;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_sum;
    logic         res_ovf;

    int checks = 0;
    int errors = 0;
    int n_load, n_drain, n_a, n_b, n_bad;

    always #5 clk = ~clk;

    unary_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_en    (add_en),
        .add_rw    (add_rw),
        .add_dout  (add_dout),
        .add_c     (add_c),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_ovf   (res_ovf)
    );

    // unary accumulator: read adds A+B with registered carry, write drains one per cycle
    logic [W-1:0] cnt_m;
    logic [W:0]   sum_m;
    assign sum_m = {1'b0, cnt_m} + (W+1)'(add_a) + (W+1)'(add_b);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_m    <= '0;
            add_dout <= 1'b0;
            add_c    <= 1'b0;
        end else if (add_en && !add_rw) begin
            cnt_m    <= sum_m[W-1:0];
            add_c    <= sum_m[W];
            add_dout <= 1'b0;
        end else if (add_en) begin
            add_dout <= (cnt_m != '0);
            if (cnt_m != '0)
                cnt_m <= cnt_m - W'(1);
            add_c <= 1'b0;
        end else begin
            add_dout <= 1'b0;
            add_c    <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (add_en && add_rw) begin
            n_drain++;
            if (add_a || add_b) n_bad++;
        end else if (add_en) begin
            n_load++;
            if (add_a) n_a++;
            if (add_b) n_b++;
        end else if (add_a || add_b) begin
            n_bad++;
        end
    end

    task automatic clear_mon();
        n_load = 0; n_drain = 0; n_a = 0; n_b = 0; n_bad = 0;
    endtask

    task automatic expect_result(input int a, input int b, input string tag);
        int s;
        logic [W-1:0] e_sum;
        logic e_ovf;
        bit got;
        s = a + b;
        e_ovf = (s > 255);
        e_sum = W'(s % 256);
`ifdef UNARY_ADD_CTRL_SAT_EN
        if (e_ovf) e_sum = '1;
`endif
        got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (res_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout res_valid=%0b want 1", tag, res_valid);
            return;
        end
        checks++;
        if (res_sum !== e_sum) begin
            errors++;
            $display("FAIL %s sum got %0d want %0d", tag, res_sum, e_sum);
        end
        checks++;
        if (res_ovf !== e_ovf) begin
            errors++;
            $display("FAIL %s ovf got %0b want %0b", tag, res_ovf, e_ovf);
        end
        checks++;
        if (n_load != ((a > b) ? a : b)) begin
            errors++;
            $display("FAIL %s load_cycles got %0d want %0d", tag, n_load, (a > b) ? a : b);
        end
        checks++;
        if (n_drain != (s % 256) + 2) begin
            errors++;
            $display("FAIL %s drain_cycles got %0d want %0d", tag, n_drain, (s % 256) + 2);
        end
        checks++;
        if (n_a != a || n_b != b) begin
            errors++;
            $display("FAIL %s pulses got a=%0d b=%0d want a=%0d b=%0d", tag, n_a, n_b, a, b);
        end
        checks++;
        if (n_bad != 0) begin
            errors++;
            $display("FAIL %s stray_pulses got %0d want 0", tag, n_bad);
        end
    endtask

    task automatic handshake_out(input string tag);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release got valid=%0b ready=%0b want 0 1", tag, res_valid, in_ready);
        end
    endtask

    task automatic send_op(input int a, input int b);
        @(negedge clk);
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        clear_mon();
        in_valid = 1'b1;
        op_a = W'(a);
        op_b = W'(b);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_op(input int a, input int b, input string tag);
        send_op(a, b);
        expect_result(a, b, tag);
        handshake_out(tag);
    endtask

    task automatic check_reset_vals(input string tag);
        checks++;
        if (in_ready !== 1'b1 || add_a !== 1'b0 || add_b !== 1'b0 ||
            add_en !== 1'b0 || add_rw !== 1'b0 || res_valid !== 1'b0 ||
            res_sum !== '0 || res_ovf !== 1'b0) begin
            errors++;
            $display("FAIL %s got rdy=%0b a=%0b b=%0b en=%0b rw=%0b v=%0b s=%0d o=%0b want 1 0 0 0 0 0 0 0",
                     tag, in_ready, add_a, add_b, add_en, add_rw, res_valid, res_sum, res_ovf);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset_hold");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("reset_idle");
    endtask

    task automatic test_directed();
        run_op(3, 2, "op_3_2");
        run_op(0, 0, "op_0_0");
        run_op(200, 100, "op_200_100");
        run_op(255, 255, "op_255_255");
        run_op(0, 7, "op_0_7");
        run_op(255, 1, "op_255_1");
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            int a, b;
            if (i % 2 == 0) begin
                a = int'($urandom_range(0, 255));
                b = int'($urandom_range(0, 255));
            end else begin
                a = int'($urandom_range(0, 12));
                b = int'($urandom_range(0, 12));
            end
            run_op(a, b, "random");
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] s0;
        logic o0;
        send_op(5, 6);
        for (int i = 0; i < 200 && !res_valid; i++) @(negedge clk);
        s0 = res_sum;
        o0 = res_ovf;
        in_valid = 1'b1;
        op_a = W'(7);
        op_b = W'(9);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_sum !== s0 || res_ovf !== o0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold got v=%0b s=%0d o=%0b rdy=%0b want 1 %0d %0b 0",
                         res_valid, res_sum, res_ovf, in_ready, s0, o0);
            end
        end
        checks++;
        if (s0 !== W'(11)) begin
            errors++;
            $display("FAIL hold_sum got %0d want 11", s0);
        end
        handshake_out("hold_release");
        clear_mon();
        @(negedge clk);
        in_valid = 1'b0;
        expect_result(7, 9, "after_hold");
        handshake_out("after_hold");
    endtask

    task automatic test_mid_reset();
        bit seen;
        send_op(3, 2);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (add_en && add_rw) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL mid_reset no_drain got rw=%0b want 1", add_rw);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("mid_reset_async");
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1, 1, "after_reset");
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_directed();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
